// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one registered multiplier between two requesters.
// One operation in flight at a time: IDLE accepts, ISSUE fires the multiplier, WAIT returns the product.
module mul_arbiter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] req0_op1,
  input  logic [WIDTH-1:0] req0_op2,
  input  logic             req1,
  input  logic [WIDTH-1:0] req1_op1,
  input  logic [WIDTH-1:0] req1_op2,
  output logic             ack0,
  output logic             ack1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] result0,
  output logic [WIDTH-1:0] result1,
  output logic             busy,
  output logic             mul_enable,
  output logic [WIDTH-1:0] mul_op1,
  output logic [WIDTH-1:0] mul_op2,
  input  logic [WIDTH-1:0] mul_result
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  state_e           state_q;
  logic             owner_q;
  logic             last_q;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic             grant_d;

  // On a tie the port that did not finish last wins
  always_comb begin
    grant_d = req1;
    if (req0 && req1) begin
      grant_d = ~last_q;
    end
  end

  // Latched operands stay on the multiplier bus; it ignores them while enable is low
  assign mul_op1 = opa_q;
  assign mul_op2 = opb_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      opa_q      <= '0;
      opb_q      <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      result0    <= '0;
      result1    <= '0;
      busy       <= 1'b0;
      mul_enable <= 1'b0;
    end else begin
      ack0  <= 1'b0;
      ack1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req0 || req1) begin
            owner_q    <= grant_d;
            opa_q      <= grant_d ? req1_op1 : req0_op1;
            opb_q      <= grant_d ? req1_op2 : req0_op2;
            ack0       <= ~grant_d;
            ack1       <= grant_d;
            busy       <= 1'b1;
            mul_enable <= 1'b1;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          mul_enable <= 1'b0;
          state_q    <= WAIT;
        end
        WAIT: begin
          if (owner_q) begin
            result1 <= mul_result;
            done1   <= 1'b1;
          end else begin
            result0 <= mul_result;
            done0   <= 1'b1;
          end
          last_q  <= owner_q;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy       <= 1'b0;
          mul_enable <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_arbiter.sv
// Bench for mul_arbiter: directed vector table, hand-written corner sequences,
// and random traffic checked every cycle against a transaction-level reference model.
module tb_mul_arbiter;
  localparam int unsigned W = 32;

  logic         clock, reset;
  logic         req0, req1;
  logic [W-1:0] req0_op1, req0_op2, req1_op1, req1_op2;
  logic         ack0, ack1, done0, done1, busy, mul_enable;
  logic [W-1:0] result0, result1, mul_op1, mul_op2, mul_result;

  int n_tests = 0;
  int n_fail  = 0;

  mul_arbiter #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req0_op1(req0_op1), .req0_op2(req0_op2),
    .req1(req1), .req1_op1(req1_op1), .req1_op2(req1_op2),
    .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
    .result0(result0), .result1(result1), .busy(busy),
    .mul_enable(mul_enable), .mul_op1(mul_op1), .mul_op2(mul_op2),
    .mul_result(mul_result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural stand-in for the registered multiplier
  always @(posedge clock) begin
    if (mul_enable) mul_result <= mul_op1 * mul_op2;
  end

  function automatic logic [W-1:0] mul_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] full;
    full = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    return full[W-1:0];
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an operation occupies the unit for the accept cycle plus two more
  int           m_left;
  logic         m_own, m_last, m_pick;
  logic [W-1:0] m_prod;
  logic         e_ack0, e_ack1, e_done0, e_done1;
  logic [W-1:0] e_res0, e_res1, e_op1, e_op2;

  assign m_pick = (req0 && req1) ? ~m_last : req1;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_left <= 0; m_own <= 1'b0; m_last <= 1'b1; m_prod <= '0;
      e_ack0 <= 1'b0; e_ack1 <= 1'b0; e_done0 <= 1'b0; e_done1 <= 1'b0;
      e_res0 <= '0; e_res1 <= '0; e_op1 <= '0; e_op2 <= '0;
    end else begin
      e_ack0 <= 1'b0; e_ack1 <= 1'b0; e_done0 <= 1'b0; e_done1 <= 1'b0;
      if (m_left == 0) begin
        if (req0 || req1) begin
          m_own  <= m_pick;
          e_op1  <= m_pick ? req1_op1 : req0_op1;
          e_op2  <= m_pick ? req1_op2 : req0_op2;
          m_prod <= m_pick ? mul_ref(req1_op1, req1_op2) : mul_ref(req0_op1, req0_op2);
          e_ack0 <= ~m_pick;
          e_ack1 <= m_pick;
          m_left <= 2;
        end
      end else if (m_left == 2) begin
        m_left <= 1;
      end else begin
        if (m_own) begin e_res1 <= m_prod; e_done1 <= 1'b1; end
        else       begin e_res0 <= m_prod; e_done0 <= 1'b1; end
        m_last <= m_own;
        m_left <= 0;
      end
    end
  end

  bit chk_on = 1'b0;
  always @(negedge clock) begin
    if (chk_on) begin
      chk1("m_ack0", ack0, e_ack0);
      chk1("m_ack1", ack1, e_ack1);
      chk1("m_done0", done0, e_done0);
      chk1("m_done1", done1, e_done1);
      chk1("m_busy", busy, m_left != 0);
      chk1("m_mul_enable", mul_enable, m_left == 2);
      chkw("m_result0", result0, e_res0);
      chkw("m_result1", result1, e_res1);
      chkw("m_mul_op1", mul_op1, e_op1);
      chkw("m_mul_op2", mul_op2, e_op2);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input bit port, input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
    if (port) begin req1 = v; req1_op1 = a; req1_op2 = b; end
    else      begin req0 = v; req0_op1 = a; req0_op2 = b; end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  // Single op from IDLE: ack after one edge, done two edges after ack
  task automatic run_op(input string nm, input bit port, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_r);
    int t;
    set_req(port, 1'b1, a, b);
    t = 0;
    while (t < 8) begin
      tick();
      t++;
      if (port ? ack1 : ack0) break;
    end
    chkw({nm, "_ack_latency"}, W'(t), W'(1));
    set_req(port, 1'b0, a, b);
    tick();
    chk1({nm, "_no_early_done"}, port ? done1 : done0, 1'b0);
    tick();
    chk1({nm, "_done"}, port ? done1 : done0, 1'b1);
    chkw({nm, "_result"}, port ? result1 : result0, exp_r);
  endtask

  typedef struct {
    bit           port;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
  } vec_t;

  vec_t         vt[6];
  logic [W-1:0] sa[3], sb[3], sr[3];

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(3, 0))
      0:       return W'($urandom_range(255, 0));
      1:       return W'($urandom);
      2:       return '1;
      default: return W'(1) << $urandom_range(W - 1, 0);
    endcase
  endfunction

  initial begin
    reset = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    req0_op1 = '0; req0_op2 = '0; req1_op1 = '0; req1_op2 = '0;
    mul_result = '0;
    vt[0] = '{1'b0, 32'd6, 32'd7, 32'd42};
    vt[1] = '{1'b1, 32'h0001_0000, 32'h0001_0000, 32'h0};
    vt[2] = '{1'b1, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE};
    vt[3] = '{1'b0, 32'd3, 32'd5, 32'd15};
    vt[4] = '{1'b1, 32'd4, 32'd4, 32'd16};
    vt[5] = '{1'b0, 32'h1234_5678, 32'd16, 32'h2345_6780};
    sa[0] = 32'd3;      sb[0] = 32'd4;        sr[0] = 32'd12;
    sa[1] = 32'd10;     sb[1] = 32'd20;       sr[1] = 32'd200;
    sa[2] = 32'hFFFF;   sb[2] = 32'h1_0001;   sr[2] = 32'hFFFF_FFFF;

    #1 do_reset();
    chk_on = 1'b1;
    chk1("rst_ack0", ack0, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_mul_enable", mul_enable, 1'b0);
    chkw("rst_result0", result0, '0);
    chkw("rst_result1", result1, '0);

    // Single request 6x7
    set_req(0, 1'b1, 32'd6, 32'd7);
    tick();
    chk1("single_ack0", ack0, 1'b1);
    chk1("single_en_on", mul_enable, 1'b1);
    chkw("single_op1", mul_op1, 32'd6);
    set_req(0, 1'b0, 32'd6, 32'd7);
    tick();
    chk1("single_en_off", mul_enable, 1'b0);
    chk1("single_ack0_off", ack0, 1'b0);
    chk1("single_busy_wait", busy, 1'b1);
    tick();
    chk1("single_done0", done0, 1'b1);
    chkw("single_result0", result0, 32'd42);
    chkw("single_result1", result1, 32'd0);
    chk1("single_idle", busy, 1'b0);
    tick();
    chk1("single_done0_pulse", done0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      run_op($sformatf("vec%0d", i), vt[i].port, vt[i].a, vt[i].b, vt[i].r);
      tick();
    end

    // Tie with both held: grants alternate 0,1,0,1 every 3 cycles
    do_reset();
    set_req(0, 1'b1, 32'd3, 32'd5);
    set_req(1, 1'b1, 32'd4, 32'd4);
    for (int t = 1; t <= 12; t++) begin
      int k, ph;
      tick();
      k = (t - 1) / 3;
      ph = (t - 1) % 3;
      chk1($sformatf("tie_ack0_t%0d", t), ack0, ph == 0 && k % 2 == 0);
      chk1($sformatf("tie_ack1_t%0d", t), ack1, ph == 0 && k % 2 == 1);
      chk1($sformatf("tie_done0_t%0d", t), done0, ph == 2 && k % 2 == 0);
      chk1($sformatf("tie_done1_t%0d", t), done1, ph == 2 && k % 2 == 1);
      if (ph == 2) chkw($sformatf("tie_res_t%0d", t), (k % 2 == 1) ? result1 : result0,
                        (k % 2 == 1) ? 32'd16 : 32'd15);
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();

    // Request from port 1 arriving while port 0 is in flight
    set_req(0, 1'b1, 32'd9, 32'd9);
    tick();
    chk1("busyreq_ack0", ack0, 1'b1);
    chk1("busyreq_busy_issue", busy, 1'b1);
    req0 = 1'b0;
    set_req(1, 1'b1, 32'd5, 32'd11);
    tick();
    chk1("busyreq_no_ack1_wait", ack1, 1'b0);
    chk1("busyreq_busy_wait", busy, 1'b1);
    tick();
    chk1("busyreq_done0", done0, 1'b1);
    chkw("busyreq_result0", result0, 32'd81);
    chk1("busyreq_no_ack1_done", ack1, 1'b0);
    tick();
    chk1("busyreq_ack1", ack1, 1'b1);
    req1 = 1'b0;
    tick();
    tick();
    chk1("busyreq_done1", done1, 1'b1);
    chkw("busyreq_result1", result1, 32'd55);
    tick();

    // Reset while in WAIT drops the op
    set_req(0, 1'b1, 32'd7, 32'd8);
    tick();
    req0 = 1'b0;
    tick();
    #2 reset = 1'b1;
    #1;
    chk1("rstmid_ack0", ack0, 1'b0);
    chk1("rstmid_done0", done0, 1'b0);
    chk1("rstmid_busy", busy, 1'b0);
    chk1("rstmid_en", mul_enable, 1'b0);
    chkw("rstmid_result0", result0, '0);
    chkw("rstmid_result1", result1, '0);
    chkw("rstmid_op1", mul_op1, '0);
    chkw("rstmid_op2", mul_op2, '0);
    tick();
    reset = 1'b0;
    for (int t = 0; t < 3; t++) begin
      tick();
      chk1("rstmid_no_done", done0, 1'b0);
    end
    run_op("rstmid_after", 1'b1, 32'd2, 32'd9, 32'd18);
    tick();

    // Port 0 streams three ops with req held high
    set_req(0, 1'b1, sa[0], sb[0]);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1($sformatf("stream_ack%0d", i), ack0, 1'b1);
      if (i < 2) set_req(0, 1'b1, sa[i+1], sb[i+1]);
      else       req0 = 1'b0;
      tick();
      chk1($sformatf("stream_nodone%0d", i), done0, 1'b0);
      tick();
      chk1($sformatf("stream_done%0d", i), done0, 1'b1);
      chkw($sformatf("stream_res%0d", i), result0, sr[i]);
    end
    tick();

    // Random traffic, checked cycle by cycle by the model
    for (int cyc = 0; cyc < 600; cyc++) begin
      tick();
      if (ack0) begin
        if ($urandom_range(1, 0) == 0) req0 = 1'b0;
        else set_req(0, 1'b1, rnd_op(), rnd_op());
      end else if (!req0 && $urandom_range(9, 0) < 4) begin
        set_req(0, 1'b1, rnd_op(), rnd_op());
      end
      if (ack1) begin
        if ($urandom_range(1, 0) == 0) req1 = 1'b0;
        else set_req(1, 1'b1, rnd_op(), rnd_op());
      end else if (!req1 && $urandom_range(9, 0) < 4) begin
        set_req(1, 1'b1, rnd_op(), rnd_op());
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (8) tick();

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
